// File: rtl/ebi_bridge_pkg.sv
// Shared definitions for the EBI register-file slave: FSM encoding and
// register-map index helpers.
package ebi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } ebi_state_e;

  localparam int IDX_ID      = 0;
  localparam int IDX_RW_BASE = 1;

  // The RO bank starts right after the RW bank, so its base depends on NUM_RW.
  function automatic int idx_ro_base(input int num_rw);
    return IDX_RW_BASE + num_rw;
  endfunction

  function automatic int idx_width(input int num_rw, input int num_ro);
    return $clog2(1 + num_rw + num_ro);
  endfunction

endpackage

// File: rtl/ebi_sync.sv
// Multi-flop synchroniser for asynchronous inputs; width, depth and reset
// value are parameters.
module ebi_sync #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before the edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= RESET_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/ebi_regfile_slave.sv
// SAM9 EBI register-file slave: synchronised strobes, one FSM serialising
// host reads/writes over an ID word, RW control bank and RO status bank.
module ebi_regfile_slave
  import ebi_bridge_pkg::*;
#(
  parameter int               DATA_W      = 16,
  parameter int               ADDR_W      = 25,
  parameter int               NUM_RW      = 4,
  parameter int               NUM_RO      = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE   = 16'hB10C,
  parameter logic [DATA_W-1:0] RW_RESET   = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     data_oe_o,
  input  logic                     cs_n_i,
  input  logic                     rd_n_i,
  input  logic                     wr_n_i,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i,
  output logic [NUM_RW-1:0]        wr_stb_o,
  output logic [NUM_RO-1:0]        rd_stb_o,
  output logic                     err_o
);

  localparam int IDX_W       = idx_width(NUM_RW, NUM_RO);
  localparam int IDX_RO_BASE = idx_ro_base(NUM_RW);

  logic [2:0] strobe_n_s;
  logic       cs_s, rd_s, wr_s;

  // Synchronisers reset to "asserted": nothing is accepted until a genuinely
  // idle bus has propagated, so a host access in flight across reset is dropped.
  ebi_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RESET_VAL(3'b000)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     ({cs_n_i, rd_n_i, wr_n_i}),
    .q_o     (strobe_n_s)
  );
  assign {cs_s, rd_s, wr_s} = ~strobe_n_s;

  ebi_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_in, idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rd_word;
  logic [DATA_W-1:0] ctrl_q [NUM_RW];
  logic [DATA_W-1:0] ctrl_d [NUM_RW];
  logic [NUM_RW-1:0] wr_stb_q, wr_stb_d;
  logic [NUM_RO-1:0] rd_stb_q, rd_stb_d, ro_hit;
  logic              oe_q, oe_d, err_q, err_d, armed_q, armed_d;
  int                rd_sel, wr_sel;

  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_W-1:IDX_W+1], addr_i[0]};

  assign idx_in = addr_i[IDX_W:1];
  assign rd_sel = int'(idx_in);
  assign wr_sel = int'(idx_q);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    ro_hit  = '0;
    if (rd_sel == IDX_ID) rd_word = ID_VALUE;
    for (int k = 0; k < NUM_RW; k++)
      if (rd_sel == IDX_RW_BASE + k) rd_word = ctrl_q[k];
    for (int k = 0; k < NUM_RO; k++)
      if (rd_sel == IDX_RO_BASE + k) begin
        rd_word   = status_i[k*DATA_W +: DATA_W];
        ro_hit[k] = 1'b1;
      end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    oe_d     = oe_q;
    err_d    = err_q;
    armed_d  = armed_q;
    rd_stb_d = '0;
    wr_stb_d = '0;
    ctrl_d   = ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if (!cs_s || (!rd_s && !wr_s)) armed_d = 1'b1;
        if (armed_q && cs_s) begin
          if (rd_s && !wr_s) begin
            state_d  = ST_RD;
            idx_d    = idx_in;
            rdata_d  = rd_word;
            oe_d     = 1'b1;
            rd_stb_d = ro_hit;
            armed_d  = 1'b0;
          end else if (wr_s && !rd_s) begin
            state_d = ST_WR;
            idx_d   = idx_in;
            wdata_d = data_i;
            armed_d = 1'b0;
          end else if (rd_s && wr_s) begin
            err_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (!rd_s || !cs_s) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          rdata_d = '0;
          armed_d = 1'b1;
        end
      end
      ST_WR: begin
        if (!wr_s || !cs_s) begin
          state_d = ST_IDLE;
          armed_d = 1'b1;
          if (wr_sel == IDX_ID) err_d = 1'b0;
          else if (wr_sel >= IDX_RO_BASE) err_d = 1'b1;
          for (int k = 0; k < NUM_RW; k++)
            if (wr_sel == IDX_RW_BASE + k) begin
              ctrl_d[k]   = wdata_q;
              wr_stb_d[k] = 1'b1;
            end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the RW bank is reset because its power-up content is architecturally
  // visible (RW_RESET); pure data-path storage would not need it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      oe_q     <= 1'b0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
      rd_stb_q <= '0;
      wr_stb_q <= '0;
      for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= RW_RESET;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      oe_q     <= oe_d;
      err_q    <= err_d;
      armed_q  <= armed_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      ctrl_q   <= ctrl_d;
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_o[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign data_o    = rdata_q;
  assign data_oe_o = oe_q;
  assign err_o     = err_q;
  assign rd_stb_o  = rd_stb_q;
  assign wr_stb_o  = wr_stb_q;

endmodule

// File: tb/tb_ebi_regfile_slave.sv
// Scoreboard bench for ebi_regfile_slave: host EBI transactions push their
// expected observations, sampling points pop and compare them.
module tb_ebi_regfile_slave;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 25;
  localparam int NUM_RW = 4;
  localparam int NUM_RO = 4;

  logic                     clk_i    = 1'b0;
  logic                     reset_i  = 1'b1;
  logic [ADDR_W-1:0]        addr_i   = '0;
  logic [DATA_W-1:0]        data_i   = '0;
  logic                     cs_n_i   = 1'b1;
  logic                     rd_n_i   = 1'b1;
  logic                     wr_n_i   = 1'b1;
  logic [NUM_RO*DATA_W-1:0] status_i = '0;
  logic [DATA_W-1:0]        data_o;
  logic                     data_oe_o;
  logic [NUM_RW*DATA_W-1:0] ctrl_o;
  logic [NUM_RW-1:0]        wr_stb_o;
  logic [NUM_RO-1:0]        rd_stb_o;
  logic                     err_o;

  ebi_regfile_slave dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .data_oe_o (data_oe_o),
    .cs_n_i    (cs_n_i),
    .rd_n_i    (rd_n_i),
    .wr_n_i    (wr_n_i),
    .ctrl_o    (ctrl_o),
    .status_i  (status_i),
    .wr_stb_o  (wr_stb_o),
    .rd_stb_o  (rd_stb_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_item_t;

  sb_item_t          sb_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] ctrl_m [NUM_RW];
  logic              err_m = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input logic [63:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'(sb_q.size()), 64'd1);
      return;
    end
    it = sb_q.pop_front();
    check(it.tag, got, it.exp);
  endtask

  function automatic logic [63:0] ctrl_flat();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < NUM_RW; k++) f[k*DATA_W +: DATA_W] = ctrl_m[k];
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int idx);
    if (idx == 0) return 16'hB10C;
    if (idx >= 1 && idx <= NUM_RW) return ctrl_m[idx-1];
    if (idx > NUM_RW && idx <= NUM_RW + NUM_RO) return status_i[(idx-NUM_RW-1)*DATA_W +: DATA_W];
    return '0;
  endfunction

  // Strobes held low for 6 clk periods, then released; samples #1 after edges.
  task automatic host_read(input int idx);
    logic [3:0] stb;
    stb = '0;
    if (idx > NUM_RW && idx <= NUM_RW + NUM_RO) stb[idx-NUM_RW-1] = 1'b1;
    sb_push("rd_oe_early", 64'd0);
    sb_push("rd_oe", 64'd1);
    sb_push("rd_data", 64'(model_read(idx)));
    sb_push("rd_stb", 64'(stb));
    sb_push("rd_stb_end", 64'd0);
    sb_push("rd_oe_hold", 64'd1);
    sb_push("rd_release", 64'd0);
    sb_push("rd_data_clr", 64'd0);
    sb_push("rd_err", 64'(err_m));
    @(negedge clk_i);
    addr_i = ADDR_W'(idx * 2);
    cs_n_i = 1'b0;
    rd_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 sb_pop(64'(data_oe_o));
    @(posedge clk_i);
    #1 sb_pop(64'(data_oe_o));
    sb_pop(64'(data_o));
    sb_pop(64'(rd_stb_o));
    @(posedge clk_i);
    #1 sb_pop(64'(rd_stb_o));
    repeat (3) @(negedge clk_i);
    cs_n_i = 1'b1;
    rd_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 sb_pop(64'(data_oe_o));
    @(posedge clk_i);
    #1 sb_pop(64'(data_oe_o));
    sb_pop(64'(data_o));
    sb_pop(64'(err_o));
    repeat (2) @(negedge clk_i);
  endtask

  task automatic host_write(input int idx, input logic [DATA_W-1:0] wdata);
    logic [3:0]  stb;
    logic [63:0] old_ctrl;
    stb      = '0;
    old_ctrl = ctrl_flat();
    if (idx == 0) err_m = 1'b0;
    else if (idx <= NUM_RW) begin
      ctrl_m[idx-1] = wdata;
      stb[idx-1]    = 1'b1;
    end else err_m = 1'b1;
    sb_push("wr_ctrl_pre", old_ctrl);
    sb_push("wr_stb_pre", 64'd0);
    sb_push("wr_ctrl", ctrl_flat());
    sb_push("wr_stb", 64'(stb));
    sb_push("wr_stb_end", 64'd0);
    sb_push("wr_err", 64'(err_m));
    @(negedge clk_i);
    addr_i = ADDR_W'(idx * 2);
    data_i = wdata;
    cs_n_i = 1'b0;
    wr_n_i = 1'b0;
    repeat (6) @(negedge clk_i);
    cs_n_i = 1'b1;
    wr_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 sb_pop(64'(ctrl_o));
    sb_pop(64'(wr_stb_o));
    @(posedge clk_i);
    #1 sb_pop(64'(ctrl_o));
    sb_pop(64'(wr_stb_o));
    @(posedge clk_i);
    #1 sb_pop(64'(wr_stb_o));
    sb_pop(64'(err_o));
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_oe;
    for (int k = 0; k < NUM_RW; k++) ctrl_m[k] = '0;

    // Reset state
    #2 reset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_oe", 64'(data_oe_o), 64'd0);
    check("rst_ctrl", 64'(ctrl_o), 64'd0);
    check("rst_stb", 64'({wr_stb_o, rd_stb_o}), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (5) @(negedge clk_i);

    status_i[15:0]  = 16'hA5A5;
    status_i[31:16] = 16'h5A5A;
    status_i[63:48] = 16'($urandom);

    host_read(0);
    host_write(2, 16'h1234);
    host_read(2);
    host_read(5);
    host_read(8);
    host_read(3);
    host_read(12);
    host_write(6, 16'hFFFF);
    host_read(1);
    host_write(0, 16'h0000);
    host_write(4, 16'($urandom));
    host_write(1, 16'hC3C3);
    host_write(15, 16'h7777);
    host_write(0, 16'h0000);

    // Read and write strobes together: no access, err set
    @(negedge clk_i);
    addr_i = ADDR_W'(4);
    cs_n_i = 1'b0;
    rd_n_i = 1'b0;
    wr_n_i = 1'b0;
    err_m  = 1'b1;
    sb_push("col_oe", 64'd0);
    sb_push("col_stb", 64'd0);
    sb_push("col_err", 64'(err_m));
    sb_push("col_ctrl", ctrl_flat());
    repeat (4) @(posedge clk_i);
    #1 sb_pop(64'(data_oe_o));
    sb_pop(64'({wr_stb_o, rd_stb_o}));
    sb_pop(64'(err_o));
    @(negedge clk_i);
    cs_n_i = 1'b1;
    rd_n_i = 1'b1;
    wr_n_i = 1'b1;
    repeat (5) @(negedge clk_i);
    sb_pop(64'(ctrl_o));
    host_write(0, 16'h0000);

    // Write strobe without chip select is ignored
    @(negedge clk_i);
    addr_i = ADDR_W'(2);
    data_i = 16'hDEAD;
    wr_n_i = 1'b0;
    sb_push("nocs_ctrl", ctrl_flat());
    sb_push("nocs_err", 64'(err_m));
    repeat (6) @(negedge clk_i);
    wr_n_i = 1'b1;
    repeat (5) @(negedge clk_i);
    sb_pop(64'(ctrl_o));
    sb_pop(64'(err_o));

    // Reset mid-read: outputs clear at once, access is not resumed
    @(negedge clk_i);
    addr_i = ADDR_W'(2);
    cs_n_i = 1'b0;
    rd_n_i = 1'b0;
    sb_push("mid_oe", 64'd1);
    sb_push("mid_data", 64'(model_read(1)));
    repeat (3) @(posedge clk_i);
    #1 sb_pop(64'(data_oe_o));
    sb_pop(64'(data_o));
    #2 reset_i = 1'b0;
    for (int k = 0; k < NUM_RW; k++) ctrl_m[k] = '0;
    err_m = 1'b0;
    #1;
    check("arst_oe", 64'(data_oe_o), 64'd0);
    check("arst_data", 64'(data_o), 64'd0);
    check("arst_ctrl", 64'(ctrl_o), ctrl_flat());
    @(negedge clk_i);
    reset_i = 1'b1;
    saw_oe  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1 saw_oe = saw_oe | data_oe_o;
    end
    check("arst_no_resume", 64'(saw_oe), 64'd0);
    @(negedge clk_i);
    cs_n_i = 1'b1;
    rd_n_i = 1'b1;
    repeat (5) @(negedge clk_i);
    host_read(0);
    host_read(1);

    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
